// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if: groups the data/status signals of lfsr_checker.
//   din_valid, din, clr_count : driven by the source side (master)
//   locked, err_pulse,
//   err_count, state_o        : driven by the checker (slave)
interface lfsr_checker_if #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned CNT_W = 16
);
   logic             din_valid;
   logic [WIDTH-1:0] din;
   logic             clr_count;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
   logic [1:0]       state_o;

   modport master (
      output din_valid, din, clr_count,
      input  locked, err_pulse, err_count, state_o
   );

   modport slave (
      input  din_valid, din, clr_count,
      output locked, err_pulse, err_count, state_o
   );
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for the 5-bit LFSR pattern (x^5 + x^3 + 1).
// Self-synchronises on the incoming words, then predicts each next word and
// flags/counts mismatches while locked.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; clears all state
//   bus   - lfsr_checker_if slave: din_valid/din/clr_count in,
//           locked/err_pulse/err_count/state_o out (all registered)
module lfsr_checker #(
   parameter int unsigned     WIDTH      = 5,
   parameter logic [WIDTH-1:0] TAP_MASK  = 5'b10100,
   parameter int unsigned     LOCK_CNT   = 4,
   parameter int unsigned     UNLOCK_CNT = 3,
   parameter int unsigned     CNT_W      = 16
) (
   input logic           clk,
   input logic           reset,
   lfsr_checker_if.slave bus
);

   localparam logic [1:0] StHunt   = 2'd0;
   localparam logic [1:0] StVerify = 2'd1;
   localparam logic [1:0] StLocked = 2'd2;

   localparam logic [3:0] LockCnt   = 4'(LOCK_CNT);
   localparam logic [3:0] UnlockCnt = 4'(UNLOCK_CNT);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [3:0]       match_q, match_d;
   logic [3:0]       bad_q, bad_d;
   logic             locked_q, locked_d;
   logic             err_pulse_q, err_pulse_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;

   logic [3:0] match_inc;
   logic [3:0] bad_inc;

   function automatic logic [WIDTH-1:0] lfsr_nxt(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], ^(v & TAP_MASK)};
   endfunction

   assign match_inc = match_q + 4'd1;
   assign bad_inc   = bad_q + 4'd1;

   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      match_d     = match_q;
      bad_d       = bad_q;
      locked_d    = locked_q;
      err_pulse_d = 1'b0;
      err_count_d = err_count_q;

      if (bus.din_valid) begin
         case (state_q)
            StHunt: begin
               // The all-zero word is the LFSR lock-up state; it can never seed.
               if (bus.din != '0) begin
                  exp_d   = lfsr_nxt(bus.din);
                  match_d = 4'd0;
                  state_d = StVerify;
               end
            end
            StVerify: begin
               if (bus.din == exp_q) begin
                  exp_d   = lfsr_nxt(exp_q);
                  match_d = match_inc;
                  if (match_inc == LockCnt) begin
                     state_d  = StLocked;
                     locked_d = 1'b1;
                     bad_d    = 4'd0;
                  end
               end else if (bus.din != '0) begin
                  exp_d   = lfsr_nxt(bus.din);
                  match_d = 4'd0;
               end else begin
                  state_d = StHunt;
               end
            end
            StLocked: begin
               // Free-running predictor: a corrupted word never reseeds it.
               exp_d = lfsr_nxt(exp_q);
               if (bus.din != exp_q) begin
                  err_pulse_d = 1'b1;
                  if (err_count_q != '1) begin
                     err_count_d = err_count_q + 1'b1;
                  end
                  bad_d = bad_inc;
                  if (bad_inc == UnlockCnt) begin
                     state_d  = StHunt;
                     locked_d = 1'b0;
                     bad_d    = 4'd0;
                  end
               end else begin
                  bad_d = 4'd0;
               end
            end
            default: state_d = StHunt;
         endcase
      end

      // Clear wins over a same-cycle increment, with or without din_valid.
      if (bus.clr_count) begin
         err_count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StHunt;
         exp_q       <= '0;
         match_q     <= 4'd0;
         bad_q       <= 4'd0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         exp_q       <= exp_d;
         match_q     <= match_d;
         bad_q       <= bad_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   assign bus.locked    = locked_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_count = err_count_q;
   assign bus.state_o   = state_q;

endmodule
